// File: rtl/irq_ctrl_n_if.sv
// rtl/irq_ctrl_n_if.sv - word-addressed register bus between mmapper and irq_ctrl_n
interface irq_ctrl_n_if;
    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;

    modport master (output a, output d, output we, input spo);
    modport slave  (input a, input d, input we, output spo);
endinterface

// File: rtl/irq_ctrl_n.sv
// rtl/irq_ctrl_n.sv - parametrised fixed-priority interrupt controller with eip handshake
module irq_ctrl_n #(
    parameter int NUM_IRQ  = 8,
    parameter int TIMER_CH = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    irq_ctrl_n_if.slave        bus,
    output logic               interrupt,
    output logic               int_istimer,
    input  logic               int_reply
);
    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [ID_W-1:0] TIMER_ID = ID_W'(TIMER_CH);

    typedef enum logic {IDLE, SERVICE} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [NUM_IRQ-1:0] en_q, en_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic               int_q, int_d;
    logic               tmr_q, tmr_d;

    logic [NUM_IRQ-1:0] eligible, rise, wdata, ack_clr, w1c_mask;
    logic [ID_W-1:0]    sel;
    logic               any_elig, ack;
    logic               wr_en, wr_pend, wr_mode, wr_eoi;
    logic               unused_d;

    assign wdata    = bus.d[NUM_IRQ-1:0];
    assign unused_d = ^bus.d;
    assign wr_en    = bus.we && (bus.a == 3'd0);
    assign wr_pend  = bus.we && (bus.a == 3'd1);
    assign wr_mode  = bus.we && (bus.a == 3'd2);
    assign wr_eoi   = bus.we && (bus.a == 3'd4);
    assign rise     = irq_in & ~irq_prev_q;

    // Scan downward so the lowest eligible index is the one left in sel.
    always_comb begin
        eligible = pend_q & en_q;
        any_elig = |eligible;
        sel      = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel = i[ID_W-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        ack      = int_q && int_reply && (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (ack) begin
                    state_d  = SERVICE;
                    cur_id_d = sel;
                end
            end
            SERVICE: begin
                if (wr_eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ack_clr = '0;
        if (ack && any_elig) ack_clr[sel] = 1'b1;
        w1c_mask = wr_pend ? wdata : '0;

        // Edge bits latch with set priority; level bits simply track the input.
        pend_d = ((pend_q & ~w1c_mask & ~ack_clr) | rise) & mode_q;
        pend_d = pend_d | (irq_in & ~mode_q);
        if (wr_mode) pend_d = pend_d & ~(wdata ^ mode_q);

        en_d   = wr_en   ? wdata : en_q;
        mode_d = wr_mode ? wdata : mode_q;
        int_d  = any_elig && (state_q == IDLE);
        tmr_d  = int_d && (sel == TIMER_ID);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_id_q   <= '0;
            en_q       <= '0;
            mode_q     <= '0;
            pend_q     <= '0;
            irq_prev_q <= '0;
            int_q      <= 1'b0;
            tmr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_id_q   <= cur_id_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            irq_prev_q <= irq_in;
            int_q      <= int_d;
            tmr_q      <= tmr_d;
        end
    end

    assign interrupt   = int_q;
    assign int_istimer = tmr_q;

    always_comb begin
        bus.spo = '0;
        case (bus.a)
            3'd0: bus.spo[NUM_IRQ-1:0] = en_q;
            3'd1: bus.spo[NUM_IRQ-1:0] = pend_q;
            3'd2: bus.spo[NUM_IRQ-1:0] = mode_q;
            3'd3: begin
                bus.spo[31]       = (state_q == SERVICE);
                bus.spo[ID_W-1:0] = cur_id_q;
            end
            3'd5: bus.spo[NUM_IRQ-1:0] = irq_in;
            default: bus.spo = '0;
        endcase
    end
endmodule

// File: tb/tb_irq_ctrl_n.sv
// tb/tb_irq_ctrl_n.sv - self-checking bench for irq_ctrl_n against a behavioural model
`timescale 1ns/1ps
module tb_irq_ctrl_n;
    localparam int NUM_IRQ  = 8;
    localparam int TIMER_CH = 0;
    localparam int unsigned MASK = 32'h0000_00FF;

    logic               clk;
    logic               rst_n;
    logic [NUM_IRQ-1:0] irq_in;
    logic               interrupt;
    logic               int_istimer;
    logic               int_reply;

    irq_ctrl_n_if bus ();

    irq_ctrl_n #(.NUM_IRQ(NUM_IRQ), .TIMER_CH(TIMER_CH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_in      (irq_in),
        .bus         (bus),
        .interrupt   (interrupt),
        .int_istimer (int_istimer),
        .int_reply   (int_reply)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: plain integers, one bit per channel.
    int unsigned m_en, m_mode, m_pend, m_prev, m_cur;
    bit          m_busy, m_int, m_tmr;

    function automatic int lowest(input int unsigned v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return m_en;
            3'd1: return m_pend;
            3'd2: return m_mode;
            3'd3: return (m_busy ? 32'h8000_0000 : 32'h0) | m_cur;
            3'd5: return 32'(irq_in);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model_blk
        int unsigned irq, wd, elig, rise, keep, np;
        int          sel;
        bit          has, ack;
        irq = 32'(irq_in);
        wd  = bus.d & MASK;
        if (!rst_n) begin
            m_en = 0; m_mode = 0; m_pend = 0; m_prev = 0; m_cur = 0;
            m_busy = 0; m_int = 0; m_tmr = 0;
        end else begin
            elig = m_pend & m_en;
            has  = (elig != 0);
            sel  = lowest(elig);
            ack  = int_reply && m_int && !m_busy;
            rise = irq & ~m_prev;
            keep = m_pend & m_mode;
            if (bus.we && bus.a == 3'd1) keep = keep & ~wd;
            if (ack && has) keep = keep & ~(32'd1 << sel);
            np = ((keep | rise) & m_mode) | (irq & ~m_mode & MASK);
            if (bus.we && bus.a == 3'd2) np = np & ~(wd ^ m_mode);
            m_int = has && !m_busy;
            m_tmr = m_int && (sel == TIMER_CH);
            if (ack) begin
                m_busy = 1;
                m_cur  = sel;
            end else if (bus.we && bus.a == 3'd4) begin
                m_busy = 0;
            end
            if (bus.we && bus.a == 3'd0) m_en = wd;
            if (bus.we && bus.a == 3'd2) m_mode = wd;
            m_pend = np;
            m_prev = irq;
        end
    end

    always @(negedge clk) begin
        chk("interrupt", 32'(interrupt), 32'(m_int));
        chk("int_istimer", 32'(int_istimer), 32'(m_tmr));
        chk("spo", bus.spo, m_read(bus.a));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.a = a; bus.d = d; bus.we = 1'b1;
        cyc();
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        bus.a = a;
        #0.1;
        chk(name, bus.spo, exp);
    endtask

    task automatic ack_pulse();
        int_reply = 1'b1;
        cyc();
        int_reply = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '1; int_reply = 1'b0;
        bus.a = 3'd0; bus.d = '0; bus.we = 1'b0;
        cyc(); cyc();
        chk("rst_interrupt", 32'(interrupt), 32'h0);
        chk("rst_istimer", 32'(int_istimer), 32'h0);
        rd(3'd0, 32'h0, "rst_enable");
        rd(3'd1, 32'h0, "rst_pending");
        rd(3'd2, 32'h0, "rst_mode");
        rd(3'd3, 32'h0, "rst_claim");
        irq_in = '0; rst_n = 1'b1;
        cyc();

        wr(3'd0, 32'hFF); wr(3'd2, 32'hFF);
        irq_in = 8'h20; cyc(); irq_in = '0;
        rd(3'd1, 32'h20, "edge_pending");
        chk("edge_int_lat1", 32'(interrupt), 32'h0);
        cyc();
        chk("edge_int_lat2", 32'(interrupt), 32'h1);
        ack_pulse();
        rd(3'd3, 32'h8000_0005, "edge_claim");
        rd(3'd1, 32'h0, "edge_pend_clr");
        cyc();
        chk("edge_int_fall", 32'(interrupt), 32'h0);
        wr(3'd4, 32'h0);
        rd(3'd3, 32'h0000_0005, "edge_eoi_claim");

        irq_in = 8'h09; cyc(); irq_in = '0; cyc();
        chk("prio_int", 32'(interrupt), 32'h1);
        chk("prio_timer", 32'(int_istimer), 32'h1);
        ack_pulse();
        rd(3'd3, 32'h8000_0000, "prio_claim0");
        rd(3'd1, 32'h08, "prio_pend3");
        wr(3'd4, 32'h0);
        cyc();
        chk("prio_int2", 32'(interrupt), 32'h1);
        chk("prio_timer2", 32'(int_istimer), 32'h0);
        ack_pulse();
        rd(3'd3, 32'h8000_0003, "prio_claim3");
        wr(3'd4, 32'h0);
        cyc();

        wr(3'd2, 32'h0); wr(3'd0, 32'h04);
        irq_in = 8'h04; cyc(); cyc();
        rd(3'd1, 32'h04, "lvl_pend");
        wr(3'd1, 32'h04);
        rd(3'd1, 32'h04, "lvl_w1c_noeff");
        chk("lvl_int", 32'(interrupt), 32'h1);
        irq_in = '0; cyc();
        rd(3'd1, 32'h0, "lvl_drop");
        chk("lvl_int_hold", 32'(interrupt), 32'h1);
        cyc();
        chk("lvl_int_fall", 32'(interrupt), 32'h0);

        wr(3'd0, 32'h0); wr(3'd2, 32'hFF);
        irq_in = 8'h02; cyc(); irq_in = '0; cyc();
        rd(3'd1, 32'h02, "mask_pend");
        chk("mask_int", 32'(interrupt), 32'h0);
        wr(3'd0, 32'h02);
        cyc();
        chk("unmask_int", 32'(interrupt), 32'h1);
        irq_in = 8'h02; bus.a = 3'd1; bus.d = 32'h02; bus.we = 1'b1;
        cyc();
        bus.we = 1'b0; irq_in = '0;
        rd(3'd1, 32'h02, "set_beats_w1c");

        ack_pulse();
        rd(3'd3, 32'h8000_0001, "ign_claim");
        cyc();
        ack_pulse();
        rd(3'd3, 32'h8000_0001, "ign_busy_ack");
        wr(3'd4, 32'h0);
        cyc(); cyc();
        chk("ign_int_low", 32'(interrupt), 32'h0);
        ack_pulse();
        rd(3'd3, 32'h0000_0001, "ign_idle_ack");

        for (int i = 0; i < 4000; i++) begin
            rst_n     = ($urandom_range(0, 399) != 0);
            irq_in    = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            int_reply = ($urandom_range(0, 3) == 0);
            bus.we    = ($urandom_range(0, 2) == 0);
            bus.a     = 3'($urandom_range(0, 7));
            bus.d     = $urandom;
            cyc();
        end
        bus.we = 1'b0; int_reply = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
